// File: rtl/stagebuf.sv
// stagebuf: fill-then-drain staging buffer on block RAM; STAGEBUF_CHECKSUM_EN adds an XOR checksum output csum
module stagebuf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              ovf,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              done
`ifdef STAGEBUF_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx, rd_addr;
  logic go, idle_op, hs, last, rd_en;
  // Control decode: start outranks fill/clear in IDLE; abort cancels any handshake
  always_comb begin
    go = state == IDLE && start;
    idle_op = state == IDLE && !start;
    hs = state == STREAM && out_ready && !abort;
    last = (ADDR_W+1)'(idx) + (ADDR_W+1)'(1) == count;
    rd_en = (state == FETCH && !abort) || (hs && !last);
    rd_addr = state == FETCH ? idx : idx + ADDR_W'(1);
  end
  // State register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // Next-state: abort returns to IDLE from any busy state
  always_comb
    state_nx = state == IDLE ? (start ? (count == '0 ? DONE : FETCH) : IDLE)
             : abort ? IDLE
             : state == FETCH ? STREAM
             : state == STREAM ? (hs && last ? DONE : STREAM)
             : IDLE;
  // Outputs decoded from state; done is suppressed by a same-cycle abort
  always_comb begin
    busy = state != IDLE;
    out_valid = state == STREAM;
    done = state == DONE && !abort;
    out_addr = idx;
    full = count == FULL_CNT;
  end
  // Fill bookkeeping: clear beats write, writes to a full buffer only flag overflow
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      ovf <= 1'b0;
    end else if (idle_op && clr) begin
      count <= '0;
      ovf <= 1'b0;
    end else if (idle_op && wr && full)
      ovf <= 1'b1;
    else if (idle_op && wr)
      count <= count + (ADDR_W+1)'(1);
  // Storage write port, unreset so it maps onto block RAM
  always_ff @(posedge clk)
    if (!rst && idle_op && !clr && wr && !full)
      mem[count[ADDR_W-1:0]] <= wr_data;
  // Drain index and registered read port feeding out_data
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      out_data <= '0;
    end else begin
      if (go)
        idx <= '0;
      else if (hs && !last)
        idx <= idx + ADDR_W'(1);
      if (rd_en)
        out_data <= mem[rd_addr];
    end
`ifdef STAGEBUF_CHECKSUM_EN
  // Running XOR of accepted words, restarted by each drain
  always_ff @(posedge clk)
    if (rst || go)
      csum <= '0;
    else if (hs)
      csum <= csum ^ out_data;
`endif
endmodule
